// File: rtl/diff_eq_tdm_sched_pkg.sv
// Shared types and term tables for the time-multiplexed difference-equation scheduler.
package diff_eq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  typedef logic [2:0] term_idx_t;

  localparam int NTERMS = 6;

  // Term order: 0=x1, 1=x2, 2=x3, 3=x4, 4=y1, 5=y2. Only x2 is subtracted.
  localparam logic [NTERMS-1:0] TERM_SUB = 6'b000010;

  // Two bits per term, term 0 in the LSBs: {0,0,0,0,1,2}, entries 6/7 unused.
  localparam logic [15:0] TERM_SHIFT = {2'd0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};

  function automatic logic term_sub(input term_idx_t idx);
    logic [7:0] m;
    m = {2'b00, TERM_SUB};
    return m[idx];
  endfunction

  function automatic logic [1:0] term_shift(input term_idx_t idx);
    return TERM_SHIFT[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/diff_eq_tdm_sched_if.sv
// Source/sink/clear handshake bundle for diff_eq_tdm_sched.
interface diff_eq_tdm_sched_if #(
  parameter int W   = 32,
  parameter int NCH = 4
);
  localparam int CW = $clog2(NCH);

  logic                 in_valid;
  logic                 in_ready;
  logic [CW-1:0]        in_ch;
  logic signed [W-1:0]  in_data;
  logic                 clr_valid;
  logic [CW-1:0]        clr_ch;
  logic                 clr_done;
  logic                 out_valid;
  logic                 out_ready;
  logic [CW-1:0]        out_ch;
  logic signed [W-1:0]  out_data;
  logic                 err_ch;
  logic                 busy;

  // Sample source / sink side
  modport master (
    output in_valid, in_ch, in_data, clr_valid, clr_ch, out_ready,
    input  in_ready, clr_done, out_valid, out_ch, out_data, err_ch, busy
  );

  // Scheduler side
  modport slave (
    input  in_valid, in_ch, in_data, clr_valid, clr_ch, out_ready,
    output in_ready, clr_done, out_valid, out_ch, out_data, err_ch, busy
  );

endinterface

// File: rtl/diff_eq_tdm_sched_hist_rf.sv
// Per-channel history {x1,x2,x3,x4,y1,y2}: one read port, one shift-update port, one clear port.
module diff_eq_hist_rf
  import diff_eq_pkg::*;
#(
  parameter int  W   = 32,
  parameter int  NCH = 4,
  localparam int CW  = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CW-1:0]       rd_ch,
  input  term_idx_t           rd_term,
  output logic signed [W-1:0] rd_data,
  input  logic                clr_en,
  input  logic [CW-1:0]       clr_ch,
  input  logic                upd_en,
  input  logic [CW-1:0]       upd_ch,
  input  logic signed [W-1:0] upd_x,
  input  logic signed [W-1:0] upd_y
);

  logic signed [W-1:0] hist [NCH][NTERMS];

  // Read mux; out-of-range channel or term reads as zero.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int t = 0; t < NTERMS; t++) begin
        if (rd_ch == CW'(c) && rd_term == 3'(t)) rd_data = hist[c][t];
      end
    end
  end

  // Clear or shift one channel; a clear to a nonexistent channel matches nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++)
        for (int t = 0; t < NTERMS; t++)
          hist[c][t] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (clr_en && clr_ch == CW'(c)) begin
          for (int t = 0; t < NTERMS; t++) hist[c][t] <= '0;
        end else if (upd_en && upd_ch == CW'(c)) begin
          hist[c][3] <= hist[c][2];
          hist[c][2] <= hist[c][1];
          hist[c][1] <= hist[c][0];
          hist[c][0] <= upd_x;
          hist[c][5] <= hist[c][4];
          hist[c][4] <= upd_y;
        end
      end
    end
  end

endmodule

// File: rtl/diff_eq_tdm_sched.sv
// Shared-accumulator scheduler for y = x1 - x2 + x3 + x4 + (y1>>>1) + (y2>>>2) over NCH channels.
//
//  state | meaning
//  IDLE  | waiting; clears served here, clear beats a sample
//  ACC   | one history term per cycle, tidx 0..5
//  OUT   | result held until sink accepts; history shifts on accept
module diff_eq_tdm_sched
  import diff_eq_pkg::*;
#(
  parameter int  W   = 32,
  parameter int  NCH = 4,
  localparam int CW  = $clog2(NCH)
) (
  input logic              clk,
  input logic              rst,
  diff_eq_tdm_sched_if.slave bus
);

  localparam logic [CW:0] NCH_W = (CW+1)'(NCH);

  state_t              state;
  term_idx_t           tidx;
  logic [CW-1:0]       ch_q;
  logic signed [W-1:0] x_q;
  logic signed [W-1:0] acc;
  logic signed [W-1:0] acc_nxt;
  logic signed [W-1:0] op;
  logic signed [W-1:0] rd_data;
  logic                out_valid_q;
  logic [CW-1:0]       out_ch_q;
  logic signed [W-1:0] out_data_q;
  logic                clr_done_q;
  logic                err_ch_q;
  logic                clr_en;
  logic                upd_en;
  logic                ch_bad;

  assign ch_bad = ({1'b0, bus.in_ch} >= NCH_W);
  assign clr_en = (state == IDLE) && bus.clr_valid;
  assign upd_en = (state == OUT) && bus.out_ready;

  diff_eq_hist_rf #(.W(W), .NCH(NCH)) u_hist (
    .clk     (clk),
    .rst     (rst),
    .rd_ch   (ch_q),
    .rd_term (tidx),
    .rd_data (rd_data),
    .clr_en  (clr_en),
    .clr_ch  (bus.clr_ch),
    .upd_en  (upd_en),
    .upd_ch  (ch_q),
    .upd_x   (x_q),
    .upd_y   (out_data_q)
  );

  // Scale the current term and fold it into the running sum (wraps mod 2^W).
  always_comb begin
    op      = rd_data >>> term_shift(tidx);
    acc_nxt = term_sub(tidx) ? (acc - op) : (acc + op);
  end

  // Sequencer, sample latch, accumulator and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tidx        <= '0;
      ch_q        <= '0;
      x_q         <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      clr_done_q  <= 1'b0;
      err_ch_q    <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      err_ch_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clr_valid) begin
            clr_done_q <= 1'b1;
          end else if (bus.in_valid) begin
            if (ch_bad) begin
              err_ch_q <= 1'b1;
            end else begin
              ch_q  <= bus.in_ch;
              x_q   <= bus.in_data;
              acc   <= '0;
              tidx  <= '0;
              state <= ACC;
            end
          end
        end
        ACC: begin
          acc <= acc_nxt;
          if (tidx == 3'(NTERMS-1)) begin
            out_valid_q <= 1'b1;
            out_ch_q    <= ch_q;
            out_data_q  <= acc_nxt;
            state       <= OUT;
          end else begin
            tidx <= tidx + 3'd1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = !rst && (state == IDLE) && !bus.clr_valid;
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
  assign bus.clr_done  = clr_done_q;
  assign bus.err_ch    = err_ch_q;

endmodule

// File: tb/tb_diff_eq_tdm_sched.sv
// Directed bench for diff_eq_tdm_sched: an NCH=4 build for the main paths, an NCH=3 build for bad channels.
module tb_diff_eq_tdm_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  diff_eq_tdm_sched_if #(.W(32), .NCH(4)) bus4 ();
  diff_eq_tdm_sched_if #(.W(32), .NCH(3)) bus3 ();

  diff_eq_tdm_sched #(.W(32), .NCH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  diff_eq_tdm_sched #(.W(32), .NCH(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sample through the NCH=4 build; stall>0 holds out_ready low that many cycles.
  task automatic run4(input string tag, input int ch, input int data, input int exp, input int stall);
    int n;
    n = 0;
    while (!bus4.in_ready && n < 50) begin tick(); n++; end
    chk({tag, "_rdy"}, bus4.in_ready, 1);
    bus4.out_ready = (stall == 0);
    bus4.in_valid  = 1'b1;
    bus4.in_ch     = 2'(ch);
    bus4.in_data   = data;
    tick();
    bus4.in_valid  = 1'b0;
    n = 1;
    while (!bus4.out_valid && n < 20) begin tick(); n++; end
    chk({tag, "_lat"}, n, 7);
    chk({tag, "_data"}, bus4.out_data, exp);
    chk({tag, "_ch"}, bus4.out_ch, ch);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_stall_v"}, bus4.out_valid, 1);
      chk({tag, "_stall_d"}, bus4.out_data, exp);
      chk({tag, "_stall_c"}, bus4.out_ch, ch);
      chk({tag, "_stall_r"}, bus4.in_ready, 0);
    end
    bus4.out_ready = 1'b1;
    tick();
    chk({tag, "_done_v"}, bus4.out_valid, 0);
    chk({tag, "_done_r"}, bus4.in_ready, 1);
  endtask

  task automatic run3(input string tag, input int ch, input int data, input int exp);
    int n;
    bus3.in_valid = 1'b1;
    bus3.in_ch    = 2'(ch);
    bus3.in_data  = data;
    tick();
    bus3.in_valid = 1'b0;
    n = 1;
    while (!bus3.out_valid && n < 20) begin tick(); n++; end
    chk({tag, "_lat"}, n, 7);
    chk({tag, "_data"}, bus3.out_data, exp);
    chk({tag, "_ch"}, bus3.out_ch, ch);
    tick();
  endtask

  task automatic clr4(input string tag, input int ch);
    bus4.clr_valid = 1'b1;
    bus4.clr_ch    = 2'(ch);
    tick();
    bus4.clr_valid = 1'b0;
    chk({tag, "_pulse"}, bus4.clr_done, 1);
    tick();
    chk({tag, "_end"}, bus4.clr_done, 0);
  endtask

  int imp [5] = '{64, 0, 0, 0, 0};
  int exp_imp [5] = '{0, 64, -32, 64, 88};

  initial begin
    bus4.in_valid = 0; bus4.in_ch = 0; bus4.in_data = 0;
    bus4.clr_valid = 0; bus4.clr_ch = 0; bus4.out_ready = 1;
    bus3.in_valid = 0; bus3.in_ch = 0; bus3.in_data = 0;
    bus3.clr_valid = 0; bus3.clr_ch = 0; bus3.out_ready = 1;

    repeat (3) tick();
    chk("rst_in_ready", bus4.in_ready, 0);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", bus4.out_valid, 0);
    chk("rst_out_data", bus4.out_data, 0);
    chk("rst_out_ch", bus4.out_ch, 0);
    chk("rst_clr_done", bus4.clr_done, 0);
    chk("rst_err_ch", bus4.err_ch, 0);
    chk("rst_busy", bus4.busy, 0);
    chk("idle_in_ready", bus4.in_ready, 1);

    // Impulse response on ch0
    for (int i = 0; i < 5; i++) run4($sformatf("t1_%0d", i), 0, imp[i], exp_imp[i], 0);

    // Same impulse on a fresh ch0, interleaved with zeros on ch1
    clr4("t2_clr", 0);
    for (int i = 0; i < 5; i++) begin
      run4($sformatf("t2_ch0_%0d", i), 0, imp[i], exp_imp[i], 0);
      run4($sformatf("t2_ch1_%0d", i), 1, 0, 0, 0);
    end

    // Backpressure on ch3: 100 then 0 -> second result 100, stalled 10 cycles
    run4("t3_a", 3, 100, 0, 0);
    run4("t3_b", 3, 0, 100, 10);

    // Clear beats a sample; other channels untouched
    clr4("t4_pre", 0);
    run4("t4_a", 0, 64, 0, 0);
    run4("t4_b", 0, 0, 64, 0);
    bus4.clr_valid = 1'b1; bus4.clr_ch = 2'd0;
    bus4.in_valid = 1'b1; bus4.in_ch = 2'd0; bus4.in_data = 5;
    #1;
    chk("t4_in_ready_clr", bus4.in_ready, 0);
    tick();
    bus4.clr_valid = 1'b0; bus4.in_valid = 1'b0;
    chk("t4_clr_done", bus4.clr_done, 1);
    chk("t4_busy", bus4.busy, 0);
    tick();
    chk("t4_clr_done_end", bus4.clr_done, 0);
    run4("t4_c", 0, 5, 0, 0);
    // ch3 history x1=0 x2=100 y1=100 y2=0 -> -100 + 50
    run4("t4_ch3", 3, 0, -50, 0);

    // Reset while the accumulator is on term 3
    bus4.in_valid = 1'b1; bus4.in_ch = 2'd0; bus4.in_data = 9;
    tick();
    bus4.in_valid = 1'b0;
    repeat (3) tick();
    chk("t5_busy_pre", bus4.busy, 1);
    rst = 1'b1;
    tick();
    chk("t5_out_valid", bus4.out_valid, 0);
    chk("t5_out_data", bus4.out_data, 0);
    chk("t5_busy", bus4.busy, 0);
    chk("t5_in_ready", bus4.in_ready, 0);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 10; i++) begin tick(); if (bus4.out_valid) seen = 1; end
      chk("t5_no_out", seen, 0);
    end
    run4("t5_after", 0, 7, 0, 0);

    // NCH=3 build: bad channel and bad clear leave history intact
    run3("t6_a", 2, 64, 0);
    bus3.in_valid = 1'b1; bus3.in_ch = 2'd3; bus3.in_data = 1000;
    #1;
    chk("t6_in_ready", bus3.in_ready, 1);
    tick();
    bus3.in_valid = 1'b0;
    chk("t6_err", bus3.err_ch, 1);
    chk("t6_busy", bus3.busy, 0);
    tick();
    chk("t6_err_end", bus3.err_ch, 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 9; i++) begin tick(); if (bus3.out_valid) seen = 1; end
      chk("t6_no_out", seen, 0);
    end
    bus3.clr_valid = 1'b1; bus3.clr_ch = 2'd3;
    tick();
    bus3.clr_valid = 1'b0;
    chk("t6_clr_done", bus3.clr_done, 1);
    tick();
    run3("t6_b", 2, 0, 64);
    run3("t6_c", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
